mips_eu_pipe: RTL and testbench

//  Parametrised two-stage successor to CPU_EU: MIPS R/I-type execute + writeback datapath.

---
 rtl/mips_eu_pipe.sv | 179 +++++++++++++++++
 tb/tb_mips_eu_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_eu_pipe.sv
// Two-stage MIPS R/I-type execute + writeback datapath.
// Stage A reads and forwards operands and runs the ALU; stage E drives the data RAM and writes back.
module mips_eu_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUOp,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic [25:0]       Instruction,
    output logic [DATA_W-1:0] SEImm,
    output logic [DATA_W-1:0] RAM_Address,
    output logic [DATA_W-1:0] Data_to_RAM,
    output logic              mem_we,
    input  logic [DATA_W-1:0] Data_from_RAM,
    output logic              Zero,
    output logic              ex_valid,
    output logic              illegal
);
    localparam int IDX_W = $clog2(NREG);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;

    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] funct;

    assign rs    = Instruction[25:21];
    assign rt    = Instruction[20:16];
    assign rd    = Instruction[15:11];
    assign shamt = Instruction[10:6];
    assign funct = Instruction[5:0];
    assign SEImm = DATA_W'($signed(Instruction[15:0]));

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [4:0]        dest_q, dest_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] rs_rf, rt_rf, op_a, rt_val, op_b, result;
    logic              bad_op, stall, accept;

    // Registers beyond NREG, and r0 when hardwired, read as zero and ignore writes.
    function automatic logic idx_live(input logic [4:0] idx);
        return (int'(idx) < NREG) && !(ZERO_REG && idx == 5'd0);
    endfunction

    function automatic logic fwd_hit(input logic [4:0] src);
        return ex_valid_q && reg_write_q && !mem_to_reg_q && dest_q == src
               && !(ZERO_REG && src == 5'd0);
    endfunction

    always_comb begin
        rs_rf  = idx_live(rs) ? rf_q[rs[IDX_W-1:0]] : '0;
        rt_rf  = idx_live(rt) ? rf_q[rt[IDX_W-1:0]] : '0;
        op_a   = fwd_hit(rs) ? alu_q : rs_rf;
        rt_val = fwd_hit(rt) ? alu_q : rt_rf;
        op_b   = ALUSrc ? SEImm : rt_val;
    end

    always_comb begin
        result = '0;
        bad_op = 1'b0;
        case (ALUOp)
            2'b00: result = op_a + op_b;
            2'b01: result = op_a - op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   result = op_a + op_b;
                    F_SUB:   result = op_a - op_b;
                    F_AND:   result = op_a & op_b;
                    F_OR:    result = op_a | op_b;
                    F_XOR:   result = op_a ^ op_b;
                    F_NOR:   result = ~(op_a | op_b);
                    F_SLT:   result = DATA_W'($signed(op_a) < $signed(op_b));
                    F_SLTU:  result = DATA_W'(op_a < op_b);
                    F_SLL:   result = (int'(shamt) >= DATA_W) ? '0 : rt_val << shamt;
                    F_SRL:   result = (int'(shamt) >= DATA_W) ? '0 : rt_val >> shamt;
                    default: bad_op = 1'b1;
                endcase
            end
            default: bad_op = 1'b1;
        endcase
    end

    // A load in stage E cannot feed stage A; hold the instruction one cycle until it is in the RF.
    always_comb begin
        stall = ex_valid_q && mem_to_reg_q && reg_write_q && dest_q != 5'd0
                && (dest_q == rs || (dest_q == rt && (!ALUSrc || MemWrite)));
        accept = in_valid && !stall;
    end

    always_comb begin
        ex_valid_d   = 1'b0;
        alu_d        = '0;
        store_d      = '0;
        dest_d       = '0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        zero_d       = 1'b0;
        illegal_d    = 1'b0;
        if (accept) begin
            ex_valid_d   = 1'b1;
            alu_d        = result;
            store_d      = rt_val;
            dest_d       = RegDst ? rd : rt;
            reg_write_d  = RegWrite && !bad_op;
            mem_to_reg_d = MemtoReg;
            mem_write_d  = MemWrite;
            zero_d       = (result == '0);
            illegal_d    = bad_op;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (ex_valid_q && reg_write_q && idx_live(dest_q))
            rf_d[dest_q[IDX_W-1:0]] = mem_to_reg_q ? Data_from_RAM : alu_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q         <= '{default: '0};
            ex_valid_q   <= 1'b0;
            alu_q        <= '0;
            store_q      <= '0;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            ex_valid_q   <= ex_valid_d;
            alu_q        <= alu_d;
            store_q      <= store_d;
            dest_q       <= dest_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
        end
    end

    assign in_ready    = !stall;
    assign RAM_Address = alu_q;
    assign Data_to_RAM = store_q;
    assign mem_we      = ex_valid_q && mem_write_q;
    assign Zero        = zero_q;
    assign ex_valid    = ex_valid_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_mips_eu_pipe.sv
// Directed bench for mips_eu_pipe: hand-computed results checked with immediate assertions.
module tb_mips_eu_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        RegDst, ALUSrc, RegWrite, MemtoReg, MemWrite;
    logic [1:0]  ALUOp;
    logic [25:0] Instruction;
    logic [31:0] SEImm, RAM_Address, Data_to_RAM, Data_from_RAM;
    logic        mem_we, Zero, ex_valid, illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] F_ADD = 6'h20, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b, F_SLL = 6'h00, F_SRL = 6'h02;

    mips_eu_pipe #(.DATA_W(32), .NREG(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Instruction(Instruction),
        .SEImm(SEImm), .RAM_Address(RAM_Address), .Data_to_RAM(Data_to_RAM),
        .mem_we(mem_we), .Data_from_RAM(Data_from_RAM), .Zero(Zero),
        .ex_valid(ex_valid), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tiny read-only RAM image: word 4 for the load-use test, word 8 to preload r31.
    function automatic logic [31:0] ramRead(input logic [31:0] addr);
        case (addr)
            32'd4:   return 32'h12341234;
            32'd8:   return 32'h13427386;
            default: return 32'h0;
        endcase
    endfunction

    assign Data_from_RAM = ramRead(RAM_Address);

    function automatic logic [25:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [25:0] itype(input logic [4:0] rs, rt, input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    task automatic applyStimulus(input logic v, rdst, asrc, input logic [1:0] op,
                                 input logic rw, m2r, mw, input logic [25:0] ins);
        in_valid    = v;
        RegDst      = rdst;
        ALUSrc      = asrc;
        ALUOp       = op;
        RegWrite    = rw;
        MemtoReg    = m2r;
        MemWrite    = mw;
        Instruction = ins;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic rOp(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        applyStimulus(1, 1, 0, 2'b10, 1, 0, 0, rtype(rs, rt, rd, sh, fn));
    endtask

    task automatic lwOp(input logic [4:0] rt, rs, input logic [15:0] imm);
        applyStimulus(1, 0, 1, 2'b00, 1, 1, 0, itype(rs, rt, imm));
    endtask

    task automatic swOp(input logic [4:0] rt, rs, input logic [15:0] imm);
        applyStimulus(1, 0, 1, 2'b00, 0, 0, 1, itype(rs, rt, imm));
    endtask

    // Non-writing add-immediate-0 so the register value appears on RAM_Address.
    task automatic readReg(input logic [4:0] r);
        applyStimulus(1, 0, 1, 2'b00, 0, 0, 0, itype(r, 5'd0, 16'h0));
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 26'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_zero", Zero, 0);
        checkOutput("rst_ram_addr", RAM_Address, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        step();
        reset = 1'b0;

        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, itype(5'd0, 5'd0, 16'hFFF0));
        checkOutput("seimm_neg", SEImm, 32'hFFFFFFF0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, itype(5'd0, 5'd0, 16'h7FFF));
        checkOutput("seimm_pos", SEImm, 32'h00007FFF);

        lwOp(5'd31, 5'd0, 16'd8);
        step();
        checkOutput("preload_addr", RAM_Address, 32'd8);
        checkOutput("preload_valid", ex_valid, 1);
        idle();
        step();
        checkOutput("bubble_valid", ex_valid, 0);

        rOp(5'd31, 5'd31, 5'd30, 5'd0, F_NOR);
        checkOutput("nor_ready", in_ready, 1);
        step();
        checkOutput("nor_r30", RAM_Address, 32'hECBD8C79);
        rOp(5'd31, 5'd30, 5'd29, 5'd0, F_SLT);
        checkOutput("slt_ready", in_ready, 1);
        step();
        checkOutput("slt_fwd", RAM_Address, 32'h0);
        checkOutput("slt_zero", Zero, 1);
        rOp(5'd31, 5'd30, 5'd29, 5'd0, F_SLTU);
        step();
        checkOutput("sltu", RAM_Address, 32'h1);
        rOp(5'd0, 5'd31, 5'd20, 5'd4, F_SLL);
        step();
        checkOutput("sll", RAM_Address, 32'h34273860);
        rOp(5'd0, 5'd31, 5'd21, 5'd4, F_SRL);
        step();
        checkOutput("srl", RAM_Address, 32'h01342738);
        rOp(5'd31, 5'd30, 5'd22, 5'd0, F_XOR);
        step();
        checkOutput("xor", RAM_Address, 32'hFFFFFFFF);

        lwOp(5'd24, 5'd0, 16'd4);
        step();
        checkOutput("lw_addr", RAM_Address, 32'd4);
        rOp(5'd24, 5'd24, 5'd25, 5'd0, F_ADD);
        checkOutput("loaduse_stall", in_ready, 0);
        step();
        checkOutput("stall_bubble", ex_valid, 0);
        checkOutput("stall_released", in_ready, 1);
        step();
        checkOutput("add_after_load", RAM_Address, 32'h24682468);
        checkOutput("add_valid", ex_valid, 1);

        swOp(5'd31, 5'd24, 16'd12);
        checkOutput("sw_ready", in_ready, 1);
        step();
        checkOutput("sw_we", mem_we, 1);
        checkOutput("sw_addr", RAM_Address, 32'h12341240);
        checkOutput("sw_data", Data_to_RAM, 32'h13427386);
        idle();
        step();
        checkOutput("sw_we_drop", mem_we, 0);

        applyStimulus(1, 0, 0, 2'b01, 0, 0, 0, itype(5'd24, 5'd24, 16'h0));
        step();
        checkOutput("beq_zero", Zero, 1);
        checkOutput("beq_valid", ex_valid, 1);

        rOp(5'd31, 5'd31, 5'd20, 5'd0, 6'b111111);
        step();
        checkOutput("bad_funct_flag", illegal, 1);
        readReg(5'd20);
        step();
        checkOutput("bad_funct_nowrite", RAM_Address, 32'h34273860);
        checkOutput("illegal_clear", illegal, 0);
        applyStimulus(1, 1, 0, 2'b11, 1, 0, 0, rtype(5'd31, 5'd31, 5'd21, 5'd0, F_ADD));
        step();
        checkOutput("aluop11_flag", illegal, 1);
        readReg(5'd21);
        step();
        checkOutput("aluop11_nowrite", RAM_Address, 32'h01342738);

        rOp(5'd31, 5'd31, 5'd0, 5'd0, F_ADD);
        step();
        checkOutput("add_r0_result", RAM_Address, 32'h2684E70C);
        readReg(5'd0);
        step();
        checkOutput("r0_no_fwd", RAM_Address, 32'h0);
        idle();
        step();
        readReg(5'd0);
        step();
        checkOutput("r0_stays_0", RAM_Address, 32'h0);
        readReg(5'd30);
        step();
        checkOutput("r30_rf", RAM_Address, 32'hECBD8C79);

        rOp(5'd31, 5'd0, 5'd26, 5'd0, F_ADD);
        step();
        swOp(5'd26, 5'd0, 16'd0);
        step();
        checkOutput("sw_fwd_data", Data_to_RAM, 32'h13427386);
        checkOutput("sw_fwd_we", mem_we, 1);

        swOp(5'd31, 5'd24, 16'd12);
        step();
        checkOutput("pre_rst_we", mem_we, 1);
        idle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_we", mem_we, 0);
        checkOutput("midrst_addr", RAM_Address, 0);
        checkOutput("midrst_data", Data_to_RAM, 0);
        checkOutput("midrst_valid", ex_valid, 0);
        reset = 1'b0;
        readReg(5'd31);
        step();
        checkOutput("rf_cleared_r31", RAM_Address, 32'h0);
        checkOutput("rf_cleared_valid", ex_valid, 1);
        readReg(5'd24);
        step();
        checkOutput("rf_cleared_r24", RAM_Address, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
